// File: rtl/qsys_irq_aggregator_if.sv
// Avalon-MM slave bus for the interrupt aggregator register file.
// The master drives the request fields and the slave returns readdata.
interface qsys_irq_aggregator_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/qsys_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source edge/level capture, masking, a
// lowest-index priority vector and a minimum-low-time hold-off on the CPU irq.
module qsys_irq_aggregator #(
   parameter int N_SOURCES = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   qsys_irq_aggregator_if.slave  avs,
   input  logic [N_SOURCES-1:0]  irq_in,
   output logic                  irq
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   function automatic logic [15:0] zext_src(input logic [N_SOURCES-1:0] v);
      return {{(16 - N_SOURCES){1'b0}}, v};
   endfunction

   // Scans from the top so the lowest set bit is the one left in idx.
   function automatic logic [3:0] lowest_index(input logic [N_SOURCES-1:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = N_SOURCES - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic                 wr_s;
   logic                 wr_pend_s;
   logic                 wr_mask_s;
   logic                 wr_mode_s;
   logic                 wr_hold_s;
   logic                 wr_ctrl_s;
   logic [N_SOURCES-1:0] wdata_src_s;

   logic [N_SOURCES-1:0] prev_r;
   logic [N_SOURCES-1:0] edge_pend_r;
   logic [N_SOURCES-1:0] mask_r;
   logic [N_SOURCES-1:0] mode_r;
   logic [15:0]          holdoff_r;
   logic                 enable_r;

   logic [N_SOURCES-1:0] edge_set_s;
   logic [N_SOURCES-1:0] edge_clr_s;
   logic [N_SOURCES-1:0] edge_pend_nxt_s;
   logic [N_SOURCES-1:0] pending_s;
   logic [N_SOURCES-1:0] active_s;
   logic                 any_active_s;
   logic                 enable_nxt_s;

   state_e               state_r;
   state_e               state_nxt_s;
   logic [15:0]          cnt_r;
   logic [15:0]          cnt_nxt_s;
   logic                 irq_r;
   logic                 irq_nxt_s;
   logic                 holdoff_busy_s;

   logic [15:0]          rd_mux_s;
   logic [15:0]          readdata_r;

   // Write strobe decode per register.
   always_comb begin
      wr_s        = avs.chipselect & ~avs.write_n;
      wr_pend_s   = wr_s & (avs.address == 3'd1);
      wr_mask_s   = wr_s & (avs.address == 3'd2);
      wr_mode_s   = wr_s & (avs.address == 3'd3);
      wr_hold_s   = wr_s & (avs.address == 3'd6);
      wr_ctrl_s   = wr_s & (avs.address == 3'd7);
      wdata_src_s = avs.writedata[N_SOURCES-1:0];
   end

   // Edge capture and pending/active views; a same-cycle set overrides a clear.
   always_comb begin
      edge_set_s      = mode_r & irq_in & ~prev_r;
      edge_clr_s      = ({N_SOURCES{wr_pend_s}} & wdata_src_s)
                      | ({N_SOURCES{wr_mode_s}} & ~wdata_src_s);
      edge_pend_nxt_s = (edge_pend_r & ~edge_clr_s) | edge_set_s;
      pending_s       = (mode_r & edge_pend_r) | (~mode_r & irq_in);
      active_s        = pending_s & mask_r;
      any_active_s    = |active_s;
      enable_nxt_s    = wr_ctrl_s ? avs.writedata[0] : enable_r;
   end

   // Software-visible configuration and edge-capture state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_r      <= {N_SOURCES{1'b0}};
         edge_pend_r <= {N_SOURCES{1'b0}};
         mask_r      <= {N_SOURCES{1'b0}};
         mode_r      <= {N_SOURCES{1'b0}};
         holdoff_r   <= 16'd0;
         enable_r    <= 1'b0;
      end else begin
         prev_r      <= irq_in;
         edge_pend_r <= edge_pend_nxt_s;
         enable_r    <= enable_nxt_s;
         if (wr_mask_s) begin
            mask_r <= wdata_src_s;
         end
         if (wr_mode_s) begin
            mode_r <= wdata_src_s;
         end
         if (wr_hold_s) begin
            holdoff_r <= avs.writedata;
         end
      end
   end

   // Output FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a disable written this cycle already forces IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (!enable_nxt_s) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_active_s) begin
                  state_nxt_s = ST_ASSERT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ASSERT: begin
               if (any_active_s) begin
                  state_nxt_s = ST_ASSERT;
               end else if (holdoff_r != 16'd0) begin
                  state_nxt_s = ST_HOLDOFF;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_HOLDOFF: begin
               if (cnt_r <= 16'd1) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_HOLDOFF;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM outputs: irq follows the next state so it registers alongside it.
   always_comb begin
      irq_nxt_s      = (state_nxt_s == ST_ASSERT);
      holdoff_busy_s = (state_r == ST_HOLDOFF);
      cnt_nxt_s      = 16'd0;
      if (!enable_nxt_s) begin
         cnt_nxt_s = 16'd0;
      end else if ((state_r == ST_ASSERT) && (state_nxt_s == ST_HOLDOFF)) begin
         cnt_nxt_s = holdoff_r;
      end else if ((state_r == ST_HOLDOFF) && (state_nxt_s == ST_HOLDOFF)) begin
         cnt_nxt_s = cnt_r - 16'd1;
      end else begin
         cnt_nxt_s = 16'd0;
      end
   end

   // Hold-off counter and registered irq line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= 16'd0;
         irq_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         irq_r <= irq_nxt_s;
      end
   end

   // Read mux for the address presented this cycle.
   always_comb begin
      rd_mux_s = 16'd0;
      case (avs.address)
         3'd0:    rd_mux_s = zext_src(irq_in);
         3'd1:    rd_mux_s = zext_src(pending_s);
         3'd2:    rd_mux_s = zext_src(mask_r);
         3'd3:    rd_mux_s = zext_src(mode_r);
         3'd4:    rd_mux_s = zext_src(active_s);
         3'd5:    rd_mux_s = {any_active_s, 11'd0, lowest_index(active_s)};
         3'd6:    rd_mux_s = holdoff_r;
         3'd7:    rd_mux_s = {14'd0, holdoff_busy_s, enable_r};
         default: rd_mux_s = 16'd0;
      endcase
   end

   // Registered read data, refreshed every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_r <= 16'd0;
      end else begin
         readdata_r <= rd_mux_s;
      end
   end

   assign avs.readdata = readdata_r;
   assign irq          = irq_r;

endmodule
